// File: rtl/lms_pkg.sv
// Shared types and width helpers for the LMS weight update sequencer.
package lms_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } lms_seq_state_t;

    // Width of the aligned update sum: mu*e*x product plus room for the x2 and the add.
    function automatic int lms_calc_width(input int width);
        return 3 * width + 2;
    endfunction

    // Fractional bits of the mu*e*x product.
    function automatic int lms_calc_frac(input int frac);
        return 3 * frac;
    endfunction

endpackage

// File: rtl/lms_tap_update.sv
// Combinational second pipeline stage of the LMS tap update:
// p2 = p1*mu, off = 2*p2, sum = w + off at full precision, then floor back to
// WIDTH bits with overflow detection.
// Build option LMS_UPDATE_SATURATE_EN: clamp the result on overflow
// (otherwise the low WIDTH bits are kept, i.e. wrap). The flag is raised either way.
module lms_tap_update
    import lms_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12
) (
    input  logic signed [2*WIDTH-1:0] p1,
    input  logic signed [WIDTH-1:0]   mu,
    input  logic signed [WIDTH-1:0]   w,
    output logic signed [WIDTH-1:0]   w_new,
    output logic                      ovr
);

    localparam int CW = lms_calc_width(WIDTH);
    localparam int CF = lms_calc_frac(FRAC);
    localparam int SH = CF - FRAC;
    localparam int RW = CW - SH;

    logic signed [3*WIDTH-1:0] p2;
    logic signed [CW-1:0]      off;
    logic signed [CW-1:0]      w_al;
    logic signed [CW-1:0]      sum;
    logic signed [RW-1:0]      res;
    logic [RW-WIDTH:0]         upper;

    // Full-precision update, floor conversion, overflow check and wrap/clamp.
    always_comb begin
        p2    = (3*WIDTH)'(p1) * (3*WIDTH)'(mu);
        off   = CW'(p2) <<< 1;
        w_al  = CW'(w) <<< SH;
        sum   = w_al + off;
        res   = RW'(sum >>> SH);
        upper = res[RW-1:WIDTH-1];
        ovr   = !((&upper) || !(|upper));
        w_new = res[WIDTH-1:0];
`ifdef LMS_UPDATE_SATURATE_EN
        if (ovr) begin
            if (res[RW-1]) begin
                w_new = {1'b1, {(WIDTH-1){1'b0}}};
            end else begin
                w_new = {1'b0, {(WIDTH-1){1'b1}}};
            end
        end
`else
`endif
    end

endmodule

// File: rtl/lms_update_sequencer.sv
// Time-multiplexed LMS weight updater. One start request walks all TAPS weights
// through a shared two-stage datapath (S1: e*x register, S2: lms_tap_update),
// one tap per cycle. Saturation on overflow is selected by LMS_UPDATE_SATURATE_EN
// inside lms_tap_update.
//
//  state | meaning
//  IDLE  | waiting for start; inputs snapshotted on acceptance
//  RUN   | issuing tap idx to S1, one per cycle
//  DRAIN | S2 writes the last tap
//  DONE  | one-cycle done pulse
module lms_update_sequencer
    import lms_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int FRAC  = 12,
    parameter int TAPS  = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    clear_weights,
    input  logic [TAPS*WIDTH-1:0]   din,
    input  logic [WIDTH-1:0]        error,
    input  logic [WIDTH-1:0]        step_size,
    output logic                    busy,
    output logic                    done,
    output logic [TAPS*WIDTH-1:0]   weights,
    output logic [TAPS-1:0]         weights_ovr
);

    localparam int IW = $clog2(TAPS);
    localparam logic [IW-1:0] LAST_IDX = IW'(TAPS - 1);

    lms_seq_state_t state, state_nxt;
    logic                      accept;
    logic [IW-1:0]             idx;
    logic signed [WIDTH-1:0]   x_q [TAPS];
    logic signed [WIDTH-1:0]   err_q;
    logic signed [WIDTH-1:0]   mu_q;
    logic signed [2*WIDTH-1:0] p1;
    logic                      v1;
    logic [IW-1:0]             idx1;
    logic signed [WIDTH-1:0]   w_bank [TAPS];
    logic [TAPS-1:0]           ovr_bank;
    logic signed [WIDTH-1:0]   w_new;
    logic                      tap_ovr;

    // State register; clear aborts any update without a done pulse.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_weights) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, start acceptance and status outputs.
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                if (start && !clear_weights) begin
                    accept    = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (idx == LAST_IDX) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy      = 1'b1;
                state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Input snapshot on acceptance and tap index walk during RUN.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx   <= '0;
            err_q <= '0;
            mu_q  <= '0;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= '0;
            end
        end else if (accept) begin
            idx   <= '0;
            err_q <= error;
            mu_q  <= step_size;
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= din[i*WIDTH +: WIDTH];
            end
        end else if (state == RUN) begin
            idx <= idx + 1'b1;
        end
    end

    // Stage 1: register e*x[idx] along with the tap it belongs to.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_weights) begin
            v1   <= 1'b0;
            p1   <= '0;
            idx1 <= '0;
        end else begin
            v1 <= (state == RUN);
            if (state == RUN) begin
                p1   <= (2*WIDTH)'(err_q) * (2*WIDTH)'(x_q[idx]);
                idx1 <= idx;
            end
        end
    end

    lms_tap_update #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC)
    ) u_tap_update (
        .p1    (p1),
        .mu    (mu_q),
        .w     (w_bank[idx1]),
        .w_new (w_new),
        .ovr   (tap_ovr)
    );

    // Stage 2 write-back into the weight bank; overflow flags are sticky.
    always_ff @(posedge clk) begin
        if (!rst_n || clear_weights) begin
            ovr_bank <= '0;
            for (int i = 0; i < TAPS; i++) begin
                w_bank[i] <= '0;
            end
        end else if (v1) begin
            w_bank[idx1] <= w_new;
            if (tap_ovr) begin
                ovr_bank[idx1] <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < TAPS; g++) begin : g_pack
        assign weights[g*WIDTH +: WIDTH] = w_bank[g];
    end

    assign weights_ovr = ovr_bank;

endmodule

// File: tb/tb_lms_update_sequencer.sv
// Self-checking bench for lms_update_sequencer: directed scenarios plus random
// updates, checked against an exact-arithmetic model of the LMS update rule.
module tb_lms_update_sequencer;

    localparam int WIDTH = 16;
    localparam int FRAC  = 12;
    localparam int TAPS  = 8;

    logic                  clk = 1'b0;
    logic                  rst_n;
    logic                  start;
    logic                  clear_weights;
    logic [TAPS*WIDTH-1:0] din;
    logic [WIDTH-1:0]      error;
    logic [WIDTH-1:0]      step_size;
    logic                  busy;
    logic                  done;
    logic [TAPS*WIDTH-1:0] weights;
    logic [TAPS-1:0]       weights_ovr;

    int     n_checks = 0;
    int     n_pass   = 0;
    longint mw [TAPS];
    bit     mo [TAPS];
    longint sx [TAPS];
    longint se;
    longint smu;

    lms_update_sequencer #(
        .WIDTH (WIDTH),
        .FRAC  (FRAC),
        .TAPS  (TAPS)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .clear_weights (clear_weights),
        .din           (din),
        .error         (error),
        .step_size     (step_size),
        .busy          (busy),
        .done          (done),
        .weights       (weights),
        .weights_ovr   (weights_ovr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_checks++;
        if (obs === exp_v) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic longint s16(input logic [15:0] v);
        return longint'(shortint'(v));
    endfunction

    task automatic set_x_all(input logic [WIDTH-1:0] v);
        for (int i = 0; i < TAPS; i++) begin
            din[i*WIDTH +: WIDTH] = v;
        end
    endtask

    task automatic model_zero();
        for (int i = 0; i < TAPS; i++) begin
            mw[i] = 0;
            mo[i] = 1'b0;
        end
    endtask

    // w_new = floor(w + 2*mu*e*x) evaluated exactly, then wrapped or clamped to 16 bits.
    task automatic model_apply();
        longint scale;
        longint sum;
        longint res;
        bit     ov;
        scale = longint'(1) <<< (2*FRAC);
        for (int i = 0; i < TAPS; i++) begin
            sum = mw[i] * scale + 2 * se * sx[i] * smu;
            res = sum >>> (2*FRAC);
            ov  = (res > 32767) || (res < -32768);
            if (ov) begin
`ifdef LMS_UPDATE_SATURATE_EN
                res = (res > 0) ? 32767 : -32768;
`else
                res = s16(res[15:0]);
`endif
            end
            mw[i] = res;
            mo[i] = mo[i] | ov;
        end
    endtask

    task automatic check_bank(input string tag);
        logic [TAPS-1:0] ef;
        for (int i = 0; i < TAPS; i++) begin
            chk($sformatf("%s_w%0d", tag, i), 64'(weights[i*WIDTH +: WIDTH]), 64'(mw[i][15:0]));
            ef[i] = mo[i];
        end
        chk($sformatf("%s_ovr", tag), 64'(weights_ovr), 64'(ef));
    endtask

    // Full update from IDLE; optionally keeps pulsing start and scrambling inputs
    // in cycles 1..TAPS+2. Returns at mid-cycle TAPS+3 (IDLE again).
    task automatic run_update(input string tag, input bit hammer);
        for (int i = 0; i < TAPS; i++) begin
            sx[i] = s16(din[i*WIDTH +: WIDTH]);
        end
        se  = s16(error);
        smu = s16(step_size);
        start = 1'b1;
        @(posedge clk); #1;
        for (int c = 1; c <= TAPS + 2; c++) begin
            start = hammer;
            if (hammer) begin
                din       = {$urandom(), $urandom(), $urandom(), $urandom()};
                error     = 16'($urandom());
                step_size = 16'($urandom());
            end
            @(negedge clk);
            chk($sformatf("%s_busy_c%0d", tag, c), 64'(busy), 64'(c <= TAPS + 1));
            chk($sformatf("%s_done_c%0d", tag, c), 64'(done), 64'(c == TAPS + 2));
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        chk($sformatf("%s_busy_end", tag), 64'(busy), 64'(0));
        chk($sformatf("%s_done_end", tag), 64'(done), 64'(0));
        model_apply();
        check_bank(tag);
    endtask

    task automatic do_clear();
        clear_weights = 1'b1;
        @(posedge clk); #1;
        clear_weights = 1'b0;
        model_zero();
    endtask

    // Start an update and kill it in cycle at_cycle with clear_weights or rst_n.
    task automatic run_abort(input string tag, input int at_cycle, input bit use_reset);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int c = 1; c < at_cycle; c++) begin
            @(posedge clk); #1;
        end
        if (use_reset) rst_n = 1'b0;
        else clear_weights = 1'b1;
        @(posedge clk); #1;
        rst_n         = 1'b1;
        clear_weights = 1'b0;
        model_zero();
        @(negedge clk);
        chk($sformatf("%s_busy", tag), 64'(busy), 64'(0));
        check_bank(tag);
        for (int c = 0; c < TAPS + 4; c++) begin
            @(negedge clk);
            chk($sformatf("%s_nodone%0d", tag, c), 64'(done | busy), 64'(0));
        end
        @(posedge clk); #1;
    endtask

    task automatic randomize_inputs(input bit small_mu);
        din       = {$urandom(), $urandom(), $urandom(), $urandom()};
        error     = 16'($urandom());
        step_size = small_mu ? 16'($urandom_range(0, 16'h0400)) : 16'($urandom());
    endtask

    initial begin
        logic [15:0] exp3;
        rst_n         = 1'b0;
        start         = 1'b0;
        clear_weights = 1'b0;
        din           = '0;
        error         = '0;
        step_size     = '0;
        model_zero();
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        check_bank("rst");
        @(posedge clk); #1;

        // 0.5 * 1.0 * 0.25 * 2 = 0.25 on every tap
        error = 16'h0800; set_x_all(16'h1000); step_size = 16'h0400;
        run_update("t1", 1'b0);
        chk("t1_w0_const", 64'(weights[WIDTH-1:0]), 64'(16'h0400));

        // preload tap 3 to 7.5, then add 2.0 -> 9.5 overflows
        do_clear();
        din = '0; din[3*WIDTH +: WIDTH] = 16'h1000;
        error = 16'h1000; step_size = 16'h3C00;
        run_update("t2a", 1'b0);
        chk("t2a_w3_const", 64'(weights[3*WIDTH +: WIDTH]), 64'(16'h7800));
        error = 16'h1000; set_x_all(16'h1000); step_size = 16'h1000;
        run_update("t2b", 1'b0);
`ifdef LMS_UPDATE_SATURATE_EN
        exp3 = 16'h7FFF;
`else
        exp3 = 16'h9800;
`endif
        chk("t2b_w3_const", 64'(weights[3*WIDTH +: WIDTH]), 64'(exp3));
        chk("t2b_ovr3", 64'(weights_ovr[3]), 64'(1));

        // negative update, then a product that floors to zero
        do_clear();
        error = 16'hF800; set_x_all(16'h1000); step_size = 16'h0400;
        run_update("t3a", 1'b0);
        chk("t3a_w0_const", 64'(weights[WIDTH-1:0]), 64'(16'hFC00));
        do_clear();
        error = 16'h0001; set_x_all(16'h0001); step_size = 16'h1000;
        run_update("t3b", 1'b0);
        chk("t3b_w5_const", 64'(weights[5*WIDTH +: WIDTH]), 64'(0));

        // start hammered while busy, then accepted immediately in cycle TAPS+3
        randomize_inputs(1'b1);
        run_update("t4a", 1'b1);
        randomize_inputs(1'b1);
        run_update("t4b", 1'b0);

        // abort by clear, then clear+start together in IDLE
        run_abort("t5a", 4, 1'b0);
        randomize_inputs(1'b0);
        run_update("t5b", 1'b0);
        start = 1'b1; clear_weights = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; clear_weights = 1'b0;
        model_zero();
        @(negedge clk);
        chk("t5c_busy0", 64'(busy), 64'(0));
        check_bank("t5c");
        @(negedge clk);
        chk("t5c_busy1", 64'(busy), 64'(0));
        @(posedge clk); #1;

        // reset mid-update, then a normal update
        randomize_inputs(1'b0);
        run_update("t6a", 1'b0);
        run_abort("t6b", 5, 1'b1);
        randomize_inputs(1'b1);
        run_update("t6c", 1'b0);

        // random accumulation sequences
        for (int k = 0; k < 6; k++) begin
            randomize_inputs(k[0]);
            run_update($sformatf("rnd%0d", k), k[1]);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
